// File: rtl/parking_pkg.sv
// Shared constants, FSM encoding and helpers for the parking fee controller.
package parking_pkg;

    localparam int CAR_W         = 3;
    localparam int TIME_W        = 10;
    localparam int COST_W        = 10;
    localparam int MAX_SLOTS     = 2 ** CAR_W;
    localparam int DEF_NUM_SLOTS = 8;
    localparam int DEF_BASE_FEE  = 2;
    localparam int DEF_RATE      = 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ENTRY_WR  = 3'd1,
        ST_EXIT_RD   = 3'd2,
        ST_EXIT_CALC = 3'd3,
        ST_EXIT_WR   = 3'd4
    } state_e;

    // One bit per addressable slot index, set where the index is a real slot.
    function automatic logic [MAX_SLOTS-1:0] slot_mask(input int num_slots);
        logic [MAX_SLOTS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            if (i < num_slots) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/parking_fee_calc.sv
// Combinational fee calculator: parked duration (modulo time width) and saturated fee.
module parking_fee_calc
    import parking_pkg::*;
#(
    parameter int BASE_FEE = DEF_BASE_FEE,
    parameter int RATE     = DEF_RATE
) (
    input  logic [TIME_W-1:0] entry_time_i,
    input  logic [TIME_W-1:0] now_time_i,
    output logic [TIME_W-1:0] dur_o,
    output logic [COST_W-1:0] cost_o
);

    localparam logic [31:0] BASE_C   = BASE_FEE;
    localparam logic [31:0] RATE_C   = RATE;
    localparam logic [31:0] COST_MAX = (32'd1 << COST_W) - 32'd1;

    logic [31:0] full_cost_s;

    // Unsigned subtraction wraps, so a timestamp that rolled over still yields the true duration.
    always_comb begin
        dur_o       = now_time_i - entry_time_i;
        full_cost_s = BASE_C + RATE_C * {{(32-TIME_W){1'b0}}, dur_o};
        if (full_cost_s > COST_MAX) begin
            cost_o = {COST_W{1'b1}};
        end else begin
            cost_o = full_cost_s[COST_W-1:0];
        end
    end

endmodule

// File: rtl/parking_fee_ctrl.sv
// Parking transaction controller: time base, occupancy tracking and entry/exit memory sequencing.
module parking_fee_ctrl
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int BASE_FEE  = DEF_BASE_FEE,
    parameter int RATE      = DEF_RATE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 time_tick,
    input  logic                 req_valid,
    input  logic                 req_exit,
    input  logic [CAR_W-1:0]     req_car,
    output logic                 req_ready,
    output logic [CAR_W-1:0]     mem_car_sel,
    output logic                 mem_write_entry,
    output logic                 mem_write_cost,
    output logic [TIME_W-1:0]    mem_entry_time_in,
    output logic [COST_W-1:0]    mem_cost_in,
    input  logic [TIME_W-1:0]    mem_entry_time_out,
    output logic                 done,
    output logic [COST_W-1:0]    done_cost,
    output logic                 err,
    output logic [NUM_SLOTS-1:0] occupied,
    output logic                 lot_full,
    output logic                 lot_empty,
    output logic [TIME_W-1:0]    now_time
);

    localparam logic [MAX_SLOTS-1:0] SLOT_MASK = slot_mask(NUM_SLOTS);

    state_e                state_q, state_d;
    logic [CAR_W-1:0]      sel_q, sel_d;
    logic [TIME_W-1:0]     ts_q, ts_d;
    logic [TIME_W-1:0]     entry_q, entry_d;
    logic [TIME_W-1:0]     now_q, now_d;
    logic [MAX_SLOTS-1:0]  occ_q, occ_d;
    logic                  wr_entry_q, wr_entry_d;
    logic                  wr_cost_q, wr_cost_d;
    logic [TIME_W-1:0]     time_in_q, time_in_d;
    logic [COST_W-1:0]     cost_in_q, cost_in_d;
    logic                  done_q, done_d;
    logic [COST_W-1:0]     done_cost_q, done_cost_d;
    logic                  err_q, err_d;
    logic                  ready_q, ready_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;

    logic                  accept_s;
    logic                  req_ok_s;
    logic [COST_W-1:0]     cost_s;
    logic [TIME_W-1:0]     dur_unused_s;

    parking_fee_calc #(
        .BASE_FEE (BASE_FEE),
        .RATE     (RATE)
    ) u_calc (
        .entry_time_i (entry_q),
        .now_time_i   (ts_q),
        .dur_o        (dur_unused_s),
        .cost_o       (cost_s)
    );

    assign accept_s = req_valid & (state_q == ST_IDLE);
    assign req_ok_s = SLOT_MASK[req_car] & (req_exit ? occ_q[req_car] : ~occ_q[req_car]);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ts_d        = ts_q;
        entry_d     = entry_q;
        occ_d       = occ_q;
        time_in_d   = time_in_q;
        cost_in_d   = cost_in_q;
        done_cost_d = done_cost_q;
        wr_entry_d  = 1'b0;
        wr_cost_d   = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (time_tick) begin
            now_d = now_q + {{(TIME_W-1){1'b0}}, 1'b1};
        end else begin
            now_d = now_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    sel_d = req_car;
                    ts_d  = now_q;
                    if (!req_ok_s) begin
                        err_d = 1'b1;
                    end else if (req_exit) begin
                        state_d = ST_EXIT_RD;
                    end else begin
                        state_d    = ST_ENTRY_WR;
                        time_in_d  = now_q;
                        wr_entry_d = 1'b1;
                        done_d     = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ENTRY_WR: begin
                occ_d[sel_q] = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_EXIT_RD: begin
                entry_d = mem_entry_time_out;
                state_d = ST_EXIT_CALC;
            end
            ST_EXIT_CALC: begin
                cost_in_d   = cost_s;
                done_cost_d = cost_s;
                wr_cost_d   = 1'b1;
                done_d      = 1'b1;
                state_d     = ST_EXIT_WR;
            end
            ST_EXIT_WR: begin
                occ_d[sel_q] = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        full_d  = &occ_d[NUM_SLOTS-1:0];
        empty_d = ~|occ_d[NUM_SLOTS-1:0];
    end

    // State and output registers; reset drops any write still in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            ts_q        <= '0;
            entry_q     <= '0;
            now_q       <= '0;
            occ_q       <= '0;
            wr_entry_q  <= 1'b0;
            wr_cost_q   <= 1'b0;
            time_in_q   <= '0;
            cost_in_q   <= '0;
            done_q      <= 1'b0;
            done_cost_q <= '0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ts_q        <= ts_d;
            entry_q     <= entry_d;
            now_q       <= now_d;
            occ_q       <= occ_d;
            wr_entry_q  <= wr_entry_d;
            wr_cost_q   <= wr_cost_d;
            time_in_q   <= time_in_d;
            cost_in_q   <= cost_in_d;
            done_q      <= done_d;
            done_cost_q <= done_cost_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
        end
    end

    assign req_ready         = ready_q;
    assign mem_car_sel       = sel_q;
    assign mem_write_entry   = wr_entry_q;
    assign mem_write_cost    = wr_cost_q;
    assign mem_entry_time_in = time_in_q;
    assign mem_cost_in       = cost_in_q;
    assign done              = done_q;
    assign done_cost         = done_cost_q;
    assign err               = err_q;
    assign occupied          = occ_q[NUM_SLOTS-1:0];
    assign lot_full          = full_q;
    assign lot_empty         = empty_q;
    assign now_time          = now_q;

endmodule

// File: tb/tb_parking_fee_ctrl.sv
// Directed bench for parking_fee_ctrl: a RATE=1 and a RATE=2 instance share one request stream.
module tb_parking_fee_ctrl;

    logic       clk;
    logic       reset_n;
    logic       time_tick;
    logic       req_valid;
    logic       req_exit;
    logic [2:0] req_car;

    logic       ready_a, we_a, wc_a, done_a, err_a, full_a, empty_a;
    logic [2:0] sel_a;
    logic [9:0] tin_a, cin_a, tout_a, dcost_a, now_a;
    logic [7:0] occ_a;
    logic       ready_b, we_b, wc_b, done_b, err_b, full_b, empty_b;
    logic [2:0] sel_b;
    logic [9:0] tin_b, cin_b, tout_b, dcost_b, now_b;
    logic [7:0] occ_b;

    logic [9:0] mem_a [8];
    logic [9:0] mem_b [8];

    int checks = 0;
    int errors = 0;
    int exp_now = 0;

    typedef struct {
        logic       is_exit;
        logic [2:0] car;
        int         ticks;
        logic       exp_err;
        logic [9:0] exp_a;
        logic [9:0] exp_b;
        logic [7:0] exp_occ;
    } txn_t;

    txn_t tbl [20];

    parking_fee_ctrl dut_a (
        .clk(clk), .reset_n(reset_n), .time_tick(time_tick),
        .req_valid(req_valid), .req_exit(req_exit), .req_car(req_car),
        .req_ready(ready_a), .mem_car_sel(sel_a),
        .mem_write_entry(we_a), .mem_write_cost(wc_a),
        .mem_entry_time_in(tin_a), .mem_cost_in(cin_a),
        .mem_entry_time_out(tout_a), .done(done_a), .done_cost(dcost_a),
        .err(err_a), .occupied(occ_a), .lot_full(full_a), .lot_empty(empty_a),
        .now_time(now_a)
    );

    parking_fee_ctrl #(.RATE(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .time_tick(time_tick),
        .req_valid(req_valid), .req_exit(req_exit), .req_car(req_car),
        .req_ready(ready_b), .mem_car_sel(sel_b),
        .mem_write_entry(we_b), .mem_write_cost(wc_b),
        .mem_entry_time_in(tin_b), .mem_cost_in(cin_b),
        .mem_entry_time_out(tout_b), .done(done_b), .done_cost(dcost_b),
        .err(err_b), .occupied(occ_b), .lot_full(full_b), .lot_empty(empty_b),
        .now_time(now_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timestamp memory models, one per instance.
    always_ff @(posedge clk) begin
        if (we_a) mem_a[sel_a] <= tin_a;
        if (we_b) mem_b[sel_b] <= tin_b;
    end
    assign tout_a = mem_a[sel_a];
    assign tout_b = mem_b[sel_b];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input txn_t t, input int idx);
        string tag;
        tag = $sformatf("txn%0d", idx);
        if (t.ticks > 0) begin
            time_tick = 1'b1;
            repeat (t.ticks) step();
            time_tick = 1'b0;
        end
        exp_now = (exp_now + t.ticks) % 1024;
        chk({tag, "_now"}, 32'(now_a), 32'(exp_now));
        chk({tag, "_ready"}, 32'(ready_a), 32'd1);
        req_valid = 1'b1;
        req_exit  = t.is_exit;
        req_car   = t.car;
        step();
        req_valid = 1'b0;
        if (t.exp_err) begin
            chk({tag, "_err"}, 32'(err_a), 32'd1);
            chk({tag, "_err_b"}, 32'(err_b), 32'd1);
            chk({tag, "_err_we"}, 32'(we_a), 32'd0);
            chk({tag, "_err_done"}, 32'(done_a), 32'd0);
            step();
            chk({tag, "_err_clr"}, 32'(err_a), 32'd0);
            chk({tag, "_err_wc"}, 32'(wc_a), 32'd0);
            chk({tag, "_occ"}, 32'(occ_a), 32'(t.exp_occ));
        end else if (!t.is_exit) begin
            chk({tag, "_we"}, 32'(we_a), 32'd1);
            chk({tag, "_done"}, 32'(done_a), 32'd1);
            chk({tag, "_tin"}, 32'(tin_a), 32'(t.exp_a));
            chk({tag, "_tin_b"}, 32'(tin_b), 32'(t.exp_b));
            chk({tag, "_wc"}, 32'(wc_a), 32'd0);
            chk({tag, "_sel"}, 32'(sel_a), 32'(t.car));
            step();
            chk({tag, "_we_clr"}, 32'(we_a), 32'd0);
            chk({tag, "_occ"}, 32'(occ_a), 32'(t.exp_occ));
            chk({tag, "_occ_b"}, 32'(occ_b), 32'(t.exp_occ));
        end else begin
            chk({tag, "_busy"}, 32'(ready_a), 32'd0);
            chk({tag, "_wc1"}, 32'(wc_a), 32'd0);
            chk({tag, "_sel"}, 32'(sel_a), 32'(t.car));
            step();
            chk({tag, "_wc2"}, 32'(wc_a), 32'd0);
            step();
            chk({tag, "_wc3"}, 32'(wc_a), 32'd1);
            chk({tag, "_we3"}, 32'(we_a), 32'd0);
            chk({tag, "_done"}, 32'(done_a), 32'd1);
            chk({tag, "_cost"}, 32'(cin_a), 32'(t.exp_a));
            chk({tag, "_cost_b"}, 32'(cin_b), 32'(t.exp_b));
            chk({tag, "_dcost"}, 32'(dcost_a), 32'(t.exp_a));
            step();
            chk({tag, "_wc_clr"}, 32'(wc_a), 32'd0);
            chk({tag, "_done_clr"}, 32'(done_a), 32'd0);
            chk({tag, "_dcost_hold"}, 32'(dcost_a), 32'(t.exp_a));
            chk({tag, "_occ"}, 32'(occ_a), 32'(t.exp_occ));
        end
    endtask

    initial begin
        //        exit  car   ticks err  cost/ts  cost_b  occ
        tbl[0]  = '{1'b0, 3'd1, 5,   1'b0, 10'd5,    10'd5,    8'h02};
        tbl[1]  = '{1'b1, 3'd1, 20,  1'b0, 10'd22,   10'd42,   8'h00};
        tbl[2]  = '{1'b0, 3'd3, 0,   1'b0, 10'd25,   10'd25,   8'h08};
        tbl[3]  = '{1'b0, 3'd3, 0,   1'b1, 10'd0,    10'd0,    8'h08};
        tbl[4]  = '{1'b1, 3'd6, 0,   1'b1, 10'd0,    10'd0,    8'h08};
        tbl[5]  = '{1'b1, 3'd3, 0,   1'b0, 10'd2,    10'd2,    8'h00};
        tbl[6]  = '{1'b0, 3'd2, 995, 1'b0, 10'd1020, 10'd1020, 8'h04};
        tbl[7]  = '{1'b1, 3'd2, 8,   1'b0, 10'd10,   10'd18,   8'h00};
        tbl[8]  = '{1'b0, 3'd5, 0,   1'b0, 10'd4,    10'd4,    8'h20};
        tbl[9]  = '{1'b1, 3'd5, 600, 1'b0, 10'd602,  10'd1023, 8'h00};
        for (int i = 0; i < 8; i++) begin
            tbl[10+i] = '{1'b0, 3'(i), 0, 1'b0, 10'd604, 10'd604, 8'((16'd2 << i) - 16'd1)};
        end
        tbl[18] = '{1'b0, 3'd4, 0,   1'b1, 10'd0,    10'd0,    8'hFF};
        tbl[19] = '{1'b1, 3'd0, 0,   1'b0, 10'd2,    10'd2,    8'hFE};

        reset_n   = 1'b0;
        time_tick = 1'b0;
        req_valid = 1'b0;
        req_exit  = 1'b0;
        req_car   = 3'd0;
        repeat (2) step();
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_strobes", 32'({we_a, wc_a}), 32'd0);
        chk("rst_mem_data", 32'({tin_a, cin_a, sel_a}), 32'd0);
        chk("rst_dcost", 32'(dcost_a), 32'd0);
        chk("rst_occ", 32'(occ_a), 32'd0);
        chk("rst_now", 32'(now_a), 32'd0);
        chk("rst_full_empty", 32'({full_a, empty_a}), 32'b01);
        chk("rst_ready", 32'(ready_a), 32'd1);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 20; i++) begin
            run_txn(tbl[i], i);
            if (i == 17) begin
                chk("fill_full", 32'(full_a), 32'd1);
                chk("fill_not_empty", 32'(empty_a), 32'd0);
            end
        end

        // Tick on the accept edge: timestamp is the pre-increment time.
        chk("tick_pre_now", 32'(now_a), 32'(exp_now));
        req_valid = 1'b1;
        req_exit  = 1'b0;
        req_car   = 3'd0;
        time_tick = 1'b1;
        step();
        req_valid = 1'b0;
        time_tick = 1'b0;
        exp_now   = (exp_now + 1) % 1024;
        chk("tick_acc_we", 32'(we_a), 32'd1);
        chk("tick_acc_ts", 32'(tin_a), 32'd604);
        chk("tick_acc_now", 32'(now_a), 32'(exp_now));
        step();
        chk("tick_acc_full", 32'(full_a), 32'd1);
        chk("tick_acc_occ", 32'(occ_a), 32'hFF);

        // Reset in the middle of an exit computation.
        req_valid = 1'b1;
        req_exit  = 1'b1;
        req_car   = 3'd1;
        step();
        req_valid = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        chk("midrst_done_err", 32'({done_a, err_a}), 32'd0);
        chk("midrst_strobes", 32'({we_a, wc_a}), 32'd0);
        chk("midrst_mem_data", 32'({tin_a, cin_a, sel_a}), 32'd0);
        chk("midrst_dcost", 32'(dcost_a), 32'd0);
        chk("midrst_occ", 32'(occ_a), 32'd0);
        chk("midrst_now", 32'(now_a), 32'd0);
        chk("midrst_full_empty", 32'({full_a, empty_a}), 32'b01);
        step();
        chk("midrst_wc_hold", 32'(wc_a), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("midrst_wc_after%0d", i), 32'({wc_a, done_a}), 32'd0);
        end
        chk("midrst_ready", 32'(ready_a), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
